game_controller: RTL and testbench

GAME_CONTROLLER -- requirements
Module: game_controller

---
 rtl/game_pkg.sv | 26 ++
 rtl/line_checker.sv | 16 +
 rtl/game_controller.sv | 121 ++++++++++++
 tb/tb_game_controller.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared state encoding and win-line masks for the tic-tac-toe controller
package game_pkg;

    typedef enum logic [2:0] {
        START = 3'd0,
        PLAY  = 3'd1,
        CHECK = 3'd2,
        WIN_X = 3'd3,
        WIN_O = 3'd4,
        TIE   = 3'd5
    } state_e;

    // Board bit 8 is top-left, row-major, bit 0 is bottom-right
    localparam logic [7:0][8:0] WIN_MASKS = {
        9'h1C0, 9'h038, 9'h007,
        9'h124, 9'h092, 9'h049,
        9'h111, 9'h054
    };

    localparam logic [8:0] FULL_BOARD = 9'h1FF;

    function automatic logic is_end(input state_e s);
        return (s == WIN_X) || (s == WIN_O) || (s == TIE);
    endfunction

endpackage

// File: rtl/line_checker.sv
// line_checker: flags whether a 9-bit occupancy matrix completes any of the 8 lines
module line_checker
    import game_pkg::*;
(
    input  logic [8:0] matrix_i,
    output logic       win_o
);

    // OR together every line whose three squares are all occupied
    always_comb begin
        win_o = 1'b0;
        for (int i = 0; i < 8; i++)
            win_o = win_o | ((matrix_i & WIN_MASKS[i]) == WIN_MASKS[i]);
    end

endmodule

// File: rtl/game_controller.sv
// game_controller: tic-tac-toe game FSM; define STARTER_ALTERNATE_EN to alternate the first mover each game
module game_controller
    import game_pkg::*;
#(
    parameter int END_HOLD_CYCLES = 100000000
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic [8:0] cuadro,
    input  logic       restart,
    output logic [8:0] x_matrix,
    output logic [8:0] o_matrix,
    output logic       turnoX,
    output logic       turnoO,
    output logic       inc_x_score,
    output logic       inc_o_score,
    output logic       cePS,
    output logic       ceSS,
    output logic       ceWinX,
    output logic       ceWinO,
    output logic       ceTie,
    output logic [2:0] state
);

    localparam int HW = $clog2(END_HOLD_CYCLES) + 1;

    state_e        state_q, state_d;
    logic [8:0]    x_q, x_d, o_q, o_d, cuadro_q;
    logic          turn_o_q, turn_o_d, starter_o_q, starter_o_d;
    logic          inc_x_q, inc_o_q;
    logic [HW-1:0] hold_q, hold_d;
    logic          click, legal, win, full, new_game, enter_end;

    assign click     = (|cuadro) && !(|cuadro_q);
    assign legal     = click && ((cuadro & (cuadro - 9'd1)) == 9'd0) && ((cuadro & (x_q | o_q)) == 9'd0);
    assign full      = (x_q | o_q) == FULL_BOARD;
    assign new_game  = (state_d == START) && (state_q != START);
    assign enter_end = is_end(state_d) && !is_end(state_q);

    line_checker u_lines (
        .matrix_i (turn_o_q ? o_q : x_q),
        .win_o    (win)
    );

    // State, board, turn, hold counter and click history registers
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            state_q     <= START;
            x_q         <= '0;
            o_q         <= '0;
            cuadro_q    <= '0;
            turn_o_q    <= 1'b0;
            starter_o_q <= 1'b0;
            inc_x_q     <= 1'b0;
            inc_o_q     <= 1'b0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            o_q         <= o_d;
            cuadro_q    <= cuadro;
            turn_o_q    <= turn_o_d;
            starter_o_q <= starter_o_d;
            inc_x_q     <= (state_q == CHECK) && (state_d == WIN_X);
            inc_o_q     <= (state_q == CHECK) && (state_d == WIN_O);
            hold_q      <= hold_d;
        end
    end

    // Next state: restart beats clicks; a win on the last square beats a tie
    always_comb begin
        state_d = state_q;
        case (state_q)
            START:             if (!restart && click) state_d = PLAY;
            PLAY:              state_d = restart ? START : (legal ? CHECK : PLAY);
            CHECK:             state_d = restart ? START : win ? (turn_o_q ? WIN_O : WIN_X) : full ? TIE : PLAY;
            WIN_X, WIN_O, TIE: if (restart && hold_q == '0) state_d = START;
            default:           state_d = START;
        endcase
    end

    // Board, turn and hold counter updates driven by the state transition
    always_comb begin
        x_d         = x_q;
        o_d         = o_q;
        turn_o_d    = turn_o_q;
        starter_o_d = starter_o_q;
        hold_d      = (hold_q != '0) ? hold_q - HW'(1) : hold_q;
        if (new_game) begin
            x_d = '0;
            o_d = '0;
`ifdef STARTER_ALTERNATE_EN
            starter_o_d = ~starter_o_q;
`endif
            turn_o_d = starter_o_d;
        end else if (state_q == PLAY && state_d == CHECK) begin
            x_d = turn_o_q ? x_q : (x_q | cuadro);
            o_d = turn_o_q ? (o_q | cuadro) : o_q;
        end else if (state_q == CHECK && state_d == PLAY) begin
            turn_o_d = ~turn_o_q;
        end
        if (enter_end) hold_d = HW'(END_HOLD_CYCLES - 1);
    end

    // Moore outputs decoded from the current state
    always_comb begin
        state       = state_q;
        x_matrix    = x_q;
        o_matrix    = o_q;
        turnoX      = (state_q == PLAY || state_q == CHECK) && !turn_o_q;
        turnoO      = (state_q == PLAY || state_q == CHECK) && turn_o_q;
        inc_x_score = inc_x_q;
        inc_o_score = inc_o_q;
        ceSS        = state_q == START;
        cePS        = state_q == PLAY || state_q == CHECK;
        ceWinX      = state_q == WIN_X;
        ceWinO      = state_q == WIN_O;
        ceTie       = state_q == TIE;
    end

endmodule

// File: tb/tb_game_controller.sv
// tb_game_controller: directed self-checking bench for game_controller with END_HOLD_CYCLES=4
module tb_game_controller;

`ifdef STARTER_ALTERNATE_EN
    localparam bit ALT = 1'b1;
`else
    localparam bit ALT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [8:0] cuadro;
    logic       restart;
    logic [8:0] x_matrix, o_matrix;
    logic       turnoX, turnoO, inc_x_score, inc_o_score;
    logic       cePS, ceSS, ceWinX, ceWinO, ceTie;
    logic [2:0] state;
    int         total = 0;
    int         bad = 0;

    game_controller #(.END_HOLD_CYCLES(4)) dut (
        .clk_100MHz  (clk),
        .reset       (rst_n),
        .cuadro      (cuadro),
        .restart     (restart),
        .x_matrix    (x_matrix),
        .o_matrix    (o_matrix),
        .turnoX      (turnoX),
        .turnoO      (turnoO),
        .inc_x_score (inc_x_score),
        .inc_o_score (inc_o_score),
        .cePS        (cePS),
        .ceSS        (ceSS),
        .ceWinX      (ceWinX),
        .ceWinO      (ceWinO),
        .ceTie       (ceTie),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic play(input logic [8:0] sq);
        cuadro = sq;
        step();
        cuadro = '0;
        step();
    endtask

    task automatic wait_restart();
        restart = 1'b1;
        repeat (4) step();
        chk("restart_to_start", 9'(state), 9'd0);
        chk("restart_board", x_matrix | o_matrix, 9'h000);
        restart = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        cuadro  = '0;
        restart = 1'b0;
        #12;
        chk("rst_state", 9'(state), 9'd0);
        chk("rst_x", x_matrix, 9'h000);
        chk("rst_o", o_matrix, 9'h000);
        chk("rst_ceSS", 9'(ceSS), 9'd1);
        chk("rst_cePS", 9'(cePS), 9'd0);
        chk("rst_turn", {7'd0, turnoX, turnoO}, 9'd0);
        chk("rst_inc", {7'd0, inc_x_score, inc_o_score}, 9'd0);
        rst_n = 1'b1;
        step();

        // game 1: X wins on the top row
        play(9'h100);
        chk("g1_play", 9'(state), 9'd1);
        chk("g1_turnX", 9'(turnoX), 9'd1);
        play(9'h100);
        chk("g1_x1", x_matrix, 9'h100);
        chk("g1_turnO", 9'(turnoO), 9'd1);
        play(9'h010);
        chk("g1_o1", o_matrix, 9'h010);
        play(9'h080);
        play(9'h001);
        cuadro = 9'h040;
        step();
        chk("g1_check", 9'(state), 9'd2);
        chk("g1_x_final", x_matrix, 9'h1C0);
        cuadro = '0;
        step();
        chk("g1_winx", 9'(state), 9'd3);
        chk("g1_o_final", o_matrix, 9'h011);
        chk("g1_inc_x", 9'(inc_x_score), 9'd1);
        chk("g1_inc_o", 9'(inc_o_score), 9'd0);
        chk("g1_ceWinX", 9'(ceWinX), 9'd1);
        chk("g1_turn_end", {7'd0, turnoX, turnoO}, 9'd0);
        restart = 1'b1;
        step();
        chk("g1_pulse_end", 9'(inc_x_score), 9'd0);
        chk("g1_hold1", 9'(state), 9'd3);
        step();
        step();
        chk("g1_hold3", 9'(state), 9'd3);
        chk("g1_frozen", x_matrix, 9'h1C0);
        step();
        chk("g1_start", 9'(state), 9'd0);
        chk("g1_clear", x_matrix | o_matrix, 9'h000);
        restart = 1'b0;

        // game 2: starter selection, illegal clicks, restart beating a click
        play(9'h020);
        chk("g2_starter", 9'(ALT ? turnoO : turnoX), 9'd1);
        play(9'h010);
        chk("g2_mv", ALT ? o_matrix : x_matrix, 9'h010);
        play(9'h010);
        chk("g2_occ_board", x_matrix | o_matrix, 9'h010);
        chk("g2_occ_state", 9'(state), 9'd1);
        chk("g2_occ_turn", 9'(ALT ? turnoX : turnoO), 9'd1);
        play(9'h003);
        chk("g2_multi_board", x_matrix | o_matrix, 9'h010);
        chk("g2_multi_turn", 9'(ALT ? turnoX : turnoO), 9'd1);
        cuadro  = 9'h008;
        restart = 1'b1;
        step();
        chk("g2_restart_state", 9'(state), 9'd0);
        chk("g2_restart_board", x_matrix | o_matrix, 9'h000);
        cuadro  = '0;
        restart = 1'b0;
        step();

        // game 3: full board with no line is a tie
        play(9'h100);
        play(9'h100); play(9'h080); play(9'h040); play(9'h010);
        play(9'h020); play(9'h008); play(9'h002); play(9'h004);
        chk("g3_before_last", 9'(state), 9'd1);
        play(9'h001);
        chk("g3_tie", 9'(state), 9'd5);
        chk("g3_x", x_matrix, 9'h163);
        chk("g3_o", o_matrix, 9'h09C);
        chk("g3_no_inc", {7'd0, inc_x_score, inc_o_score}, 9'd0);
        chk("g3_ceTie", 9'(ceTie), 9'd1);
        wait_restart();

        // game 4: the ninth move completes a diagonal, so win beats tie
        play(9'h100);
        play(9'h100); play(9'h080); play(9'h040); play(9'h020);
        play(9'h010); play(9'h008); play(9'h002); play(9'h004);
        chk("g4_before_last", 9'(state), 9'd1);
        play(9'h001);
        chk("g4_win", 9'(state), ALT ? 9'd4 : 9'd3);
        chk("g4_mv", ALT ? o_matrix : x_matrix, 9'h153);
        chk("g4_other", ALT ? x_matrix : o_matrix, 9'h0AC);
        chk("g4_inc_mv", 9'(ALT ? inc_o_score : inc_x_score), 9'd1);
        chk("g4_inc_other", 9'(ALT ? inc_x_score : inc_o_score), 9'd0);
        chk("g4_ce", 9'(ALT ? ceWinO : ceWinX), 9'd1);
        wait_restart();

        // game 5: asynchronous reset in the middle of play
        play(9'h100);
        play(9'h010);
        chk("g5_mid_play", 9'(state), 9'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", 9'(state), 9'd0);
        chk("arst_board", x_matrix | o_matrix, 9'h000);
        chk("arst_ce", {4'd0, ceSS, cePS, ceWinX, ceWinO, ceTie}, 9'h010);
        chk("arst_turn", {7'd0, turnoX, turnoO}, 9'd0);
        chk("arst_inc", {7'd0, inc_x_score, inc_o_score}, 9'd0);
        #1 rst_n = 1'b1;
        step();
        play(9'h100);
        chk("post_rst_starterX", 9'(turnoX), 9'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
